// File: rtl/rom_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_arbiter_if                                               |
// | Description : Requester-side bundle of the shared lookup-ROM arbiter.      |
// |               Carries the per-requester lookup handshake and the tagged    |
// |               response bus.                                                |
// | Signals     : req_valid_i [NUM_REQ]            lookup pending per requester |
// |               req_addr_i  [NUM_REQ*ADDR_WIDTH] packed lookup addresses      |
// |               req_ready_o [NUM_REQ]            one-hot grant                |
// |               rsp_valid_o [NUM_REQ]            one-hot response owner       |
// |               rsp_data_o  [DATA_WIDTH]         shared response data         |
// | Modports    : slave  - arbiter side (directions follow the _i/_o suffixes) |
// |               master - requester side                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface rom_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_data_o
  );

  modport master (
    output req_valid_i,
    output req_addr_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_data_o
  );

endinterface
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_arbiter                                                  |
// | Description : Shares one synchronous single-port lookup ROM between        |
// |               NUM_REQ requesters. Work-conserving round-robin grant of at  |
// |               most one lookup per cycle, fully pipelined; read data is     |
// |               returned tagged (one-hot) to the issuing requester           |
// |               ROM_LATENCY cycles after the grant.                          |
// | Ports       : clk_i          in   clock, rising edge                       |
// |               rst_i          in   synchronous active-high reset            |
// |               bus_if         slave requester handshake / response bundle  |
// |               rom_addr_o     out  address to the ROM                      |
// |               rom_data_i     in   data from the ROM                        |
// |               perf_clr_i     in   (ROM_ARB_PERF_EN) clear grant counters   |
// |               perf_grants_o  out  (ROM_ARB_PERF_EN) 16b counter per req    |
// | Config      : ROM_ARB_PERF_EN - adds saturating per-requester grant        |
// |               counters; arbitration is identical either way.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rom_arbiter_if.slave          bus_if,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i
`ifdef ROM_ARB_PERF_EN
  ,
  input  logic                  perf_clr_i,
  output logic [NUM_REQ*16-1:0] perf_grants_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so pointer + offset never overflows before the wrap.
  localparam int IDX_W = PTR_W + 1;

  // --------------------------------------------------------------------------
  // Round-robin pointer
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;

  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   scan_idx;

  // Scan the valid vector starting at the pointer, wrapping to 0; the first
  // requester found wins. Reset suppresses any grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_REQ)) begin
        scan_idx = scan_idx - IDX_W'(NUM_REQ);
      end
      if (!grant_vld && bus_if.req_valid_i[scan_idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
    if (rst_i) begin
      grant_vld = 1'b0;
      grant_idx = '0;
    end
  end

  assign grant_oh = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

  // Next search starts just past the winner so every requester is served
  // within NUM_REQ-1 cycles under full load.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus_if.req_ready_o = grant_oh;

  // --------------------------------------------------------------------------
  // ROM address: the ROM samples it on the same edge that completes the
  // transfer, so it is driven combinationally from the grant.
  // --------------------------------------------------------------------------
  always_comb begin
    rom_addr_o = '0;
    if (grant_vld) begin
      rom_addr_o = bus_if.req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe: tracks which requester owns each lookup in flight, matched to
  // the ROM read latency so the last stage lines up with rom_data_i.
  // --------------------------------------------------------------------------
  logic               tag_vld_q [ROM_LATENCY];
  logic [NUM_REQ-1:0] tag_id_q  [ROM_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_oh;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // A response due in a reset cycle belongs to a discarded lookup, so it is
  // masked here rather than waiting for the pipe to clear on the next edge.
  logic rsp_any;

  assign rsp_any            = tag_vld_q[ROM_LATENCY-1] && !rst_i;
  assign bus_if.rsp_valid_o = rsp_any ? tag_id_q[ROM_LATENCY-1] : '0;
  assign bus_if.rsp_data_o  = rsp_any ? rom_data_i : '0;

`ifdef ROM_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Per-requester saturating grant counters. Clear has priority over a
  // same-cycle increment.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || perf_clr_i) begin
        cnt_q <= '0;
      end else if (grant_oh[i] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign perf_grants_o[i*16 +: 16] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rom_arbiter                                               |
// | Description : Self-checking bench for rom_arbiter with an AES S-box ROM    |
// |               (NUM_REQ=4, ROM_LATENCY=1). Directed scenarios followed by   |
// |               randomized traffic against a round-robin reference model.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int L  = 1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  rom_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ROM_ARB_PERF_EN
  logic          perf_clr;
  logic [N*16-1:0] perf_grants;
`endif

  rom_arbiter #(
    .NUM_REQ     (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .ROM_LATENCY (L)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus_if      (bus),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data)
`ifdef ROM_ARB_PERF_EN
    ,
    .perf_clr_i    (perf_clr),
    .perf_grants_o (perf_grants)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous S-box ROM, one cycle read latency.
  always @(posedge clk) rom_data <= SBOX[rom_addr];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_ptr;
  int pipe_id [$];
  int pipe_d  [$];

  // Last observed DUT outputs
  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rv;
  logic [DW-1:0] obs_rd;
  logic [AW-1:0] obs_addr;

  int exp_g4 [5] = '{0, 1, 2, 3, 0};
  int addr4  [4] = '{8'h00, 8'h01, 8'h53, 8'hFF};
  int data4  [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};
  int data8  [8] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Runs one clock cycle with the currently driven inputs: checks all outputs
  // mid-cycle against the model, then advances the model and the clock.
  task automatic cycle();
    int            g;
    logic [N-1:0]  e_ready;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;
    #4;
    g       = rst ? -1 : rr_pick(bus.req_valid_i, m_ptr);
    e_ready = (g >= 0) ? N'(1) << g : '0;
    e_addr  = (g >= 0) ? bus.req_addr_i[g*AW +: AW] : '0;
    e_rv    = (pipe_id[0] >= 0 && !rst) ? N'(1) << pipe_id[0] : '0;
    e_rd    = (pipe_id[0] >= 0 && !rst) ? DW'(pipe_d[0]) : '0;
    obs_ready = bus.req_ready_o;
    obs_rv    = bus.rsp_valid_o;
    obs_rd    = bus.rsp_data_o;
    obs_addr  = rom_addr;
    check("req_ready", 32'(obs_ready), 32'(e_ready));
    check("rom_addr",  32'(obs_addr),  32'(e_addr));
    check("rsp_valid", 32'(obs_rv),    32'(e_rv));
    check("rsp_data",  32'(obs_rd),    32'(e_rd));
    void'(pipe_id.pop_front());
    void'(pipe_d.pop_front());
    if (rst) begin
      m_ptr = 0;
      foreach (pipe_id[i]) pipe_id[i] = -1;
      pipe_id.push_back(-1);
      pipe_d.push_back(0);
    end else begin
      pipe_id.push_back(g);
      pipe_d.push_back((g >= 0) ? int'(SBOX[e_addr]) : 0);
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid_i = '0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
`ifdef ROM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    m_ptr = 0;
    for (int i = 0; i < L; i++) begin
      pipe_id.push_back(-1);
      pipe_d.push_back(0);
    end
    @(posedge clk);
    #1;

    // Reset state, with every requester asking
    bus.req_valid_i = '1;
    bus.req_addr_i  = '1;
    cycle();
    cycle();
    check("reset_ready", 32'(obs_ready), 32'h0);
    check("reset_rsp_valid", 32'(obs_rv), 32'h0);
    check("reset_rsp_data", 32'(obs_rd), 32'h0);
    check("reset_rom_addr", 32'(obs_addr), 32'h0);
    rst = 1'b0;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;

    // Single request
    bus.req_valid_i = 4'b0001;
    cycle();
    check("single_ready", 32'(obs_ready), 32'h1);
    bus.req_valid_i = '0;
    cycle();
    check("single_rsp_valid", 32'(obs_rv), 32'h1);
    check("single_rsp_data", 32'(obs_rd), 32'h63);

    // All four requesters held valid
    do_reset();
    for (int i = 0; i < N; i++) bus.req_addr_i[i*AW +: AW] = AW'(addr4[i]);
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus.req_valid_i = '0;
      cycle();
      if (k < 5) check("all4_grant", 32'(obs_ready), 32'(N'(1) << exp_g4[k]));
      if (k >= 1) check("all4_rsp_valid", 32'(obs_rv), 32'(N'(1) << exp_g4[k-1]));
      if (k >= 1) check("all4_rsp_data", 32'(obs_rd), 32'(data4[(k-1) % 4]));
    end

    // Requesters 1 and 3 only
    do_reset();
    bus.req_valid_i = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("alt13_grant", 32'(obs_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
    end

    // Back-to-back on requester 2
    do_reset();
    bus.req_addr_i = '0;
    for (int k = 0; k < 9; k++) begin
      bus.req_valid_i = (k < 8) ? 4'b0100 : 4'b0000;
      bus.req_addr_i[2*AW +: AW] = AW'(k);
      cycle();
      if (k < 8) check("b2b_grant", 32'(obs_ready), 32'h4);
      if (k >= 1) check("b2b_rsp_valid", 32'(obs_rv), 32'h4);
      if (k >= 1) check("b2b_rsp_data", 32'(obs_rd), 32'(data8[k-1]));
    end

    // Reset the cycle after a grant
    do_reset();
    bus.req_valid_i = 4'b0010;
    bus.req_addr_i  = '0;
    cycle();
    cycle();
    bus.req_valid_i = 4'b0001;
    cycle();
    check("midrst_grant", 32'(obs_ready), 32'h1);
    rst = 1'b1;
    bus.req_valid_i = 4'b1010;
    cycle();
    check("midrst_rsp_in_reset", 32'(obs_rv), 32'h0);
    rst = 1'b0;
    cycle();
    check("midrst_rsp_after", 32'(obs_rv), 32'h0);
    check("midrst_first_grant", 32'(obs_ready), 32'h2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.req_valid_i = N'($urandom);
      bus.req_addr_i  = (N*AW)'($urandom);
      cycle();
    end
    rst = 1'b0;

`ifdef ROM_ARB_PERF_EN
    do_reset();
    bus.req_valid_i = 4'b0001;
    for (int k = 0; k < 70000; k++) cycle();
    bus.req_valid_i = '0;
    check("perf_saturate", 32'(perf_grants[15:0]), 32'hFFFF);
    check("perf_others", 32'(perf_grants[N*16-1:16]), 32'h0);
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    check("perf_clear", 32'(perf_grants[15:0]), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
